irq_ctrl: RTL and testbench

// Machine external interrupt controller; the source side of the core's interrupt interface.

---
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine external interrupt controller with fixed lowest-index
// priority and a claim/complete handshake on a small register port.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic               irq_o
);

  typedef enum logic {IDLE, CLAIMED} state_e;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_TRIG = 2'd2;
  localparam logic [1:0] A_CLM  = 2'd3;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, pending_q, pending_d, enable_q, enable_d;
  logic [NUM_SRC-1:0] trigger_q, trigger_d, insvc_q, insvc_d;
  logic [4:0]         claim_id_q, claim_id_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d, irq_q, irq_d;

  logic [NUM_SRC-1:0] set_ev, cand;
  logic               win_hit;
  logic [4:0]         win_idx;
  logic               rd_acc, wr_acc;

  // Address low bits and unused write-data bits are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, addr_i[1:0], wdata_i};

  assign rd_acc = req_i & ~we_i;
  assign wr_acc = req_i & we_i;

  // Gateway event and lowest-index enabled pending winner (pre-edge values).
  always_comb begin
    set_ev  = (trigger_q & src_i & ~src_q) | (~trigger_q & src_i);
    cand    = pending_q & enable_q;
    win_hit = 1'b0;
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_hit = 1'b1;
        win_idx = 5'(i);
      end
    end
  end

  // Next-state: register writes, claim/complete handshake, read data, irq.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | (set_ev & ~insvc_q);
    enable_d   = enable_q;
    trigger_d  = trigger_q;
    insvc_d    = insvc_q;
    claim_id_d = claim_id_q;
    rdata_d    = rdata_q;
    rvalid_d   = rd_acc;

    if (rd_acc) begin
      case (addr_i[3:2])
        A_PEND: rdata_d = 32'(pending_q);
        A_EN:   rdata_d = 32'(enable_q);
        A_TRIG: rdata_d = 32'(trigger_q);
        default: begin
          rdata_d = '0;
          // A claim beats a same-cycle gateway set on the winning source.
          if (state_q == IDLE && win_hit) begin
            rdata_d            = 32'(win_idx) + 32'd1;
            pending_d[win_idx] = 1'b0;
            insvc_d[win_idx]   = 1'b1;
            claim_id_d         = win_idx + 5'd1;
            state_d            = CLAIMED;
          end
        end
      endcase
    end

    if (wr_acc) begin
      case (addr_i[3:2])
        A_EN:   enable_d  = wdata_i[NUM_SRC-1:0];
        A_TRIG: trigger_d = wdata_i[NUM_SRC-1:0];
        A_CLM: begin
          if (state_q == CLAIMED && wdata_i[4:0] == claim_id_q) begin
            insvc_d = '0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    irq_d = (state_d == IDLE) && (|(pending_d & enable_d));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      src_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      trigger_q  <= '0;
      insvc_q    <= '0;
      claim_id_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_i;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      trigger_q  <= trigger_d;
      insvc_q    <= insvc_d;
      claim_id_q <= claim_id_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked against a
// behavioural model of the interrupt controller.
module tb_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  src_i = '0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        rvalid_o, irq_o;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.NUM_SRC(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .src_i(src_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: per-source bit vectors and a claimed ID (0 = none claimed).
  logic [7:0]  m_pend, m_en, m_trig, m_svc, m_srcq;
  int          m_id;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;
  logic [7:0]  cur_src;

  task automatic model_reset();
    m_pend = 0; m_en = 0; m_trig = 0; m_svc = 0; m_srcq = 0;
    m_id = 0; m_rdata = 0; m_rvalid = 0; m_irq = 0;
  endtask

  task automatic model_edge(input logic [7:0] s, input logic rq, input logic w,
                            input logic [3:0] a, input logic [31:0] wd);
    logic [7:0] hit, newp;
    int win;
    newp = m_pend;
    for (int i = 0; i < 8; i++) begin
      hit[i] = m_trig[i] ? (s[i] && !m_srcq[i]) : s[i];
      if (hit[i] && !m_svc[i]) newp[i] = 1'b1;
    end
    m_rvalid = rq && !w;
    if (rq && !w) begin
      case (a[3:2])
        2'd0: m_rdata = {24'd0, m_pend};
        2'd1: m_rdata = {24'd0, m_en};
        2'd2: m_rdata = {24'd0, m_trig};
        default: begin
          m_rdata = 0;
          win = -1;
          for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
          if (m_id == 0 && win >= 0) begin
            m_rdata = win + 1;
            newp[win] = 1'b0;
            m_svc[win] = 1'b1;
            m_id = win + 1;
          end
        end
      endcase
    end
    if (rq && w) begin
      if (a[3:2] == 2'd1) m_en = wd[7:0];
      if (a[3:2] == 2'd2) m_trig = wd[7:0];
      if (a[3:2] == 2'd3 && m_id != 0 && int'(wd[4:0]) == m_id) begin
        m_svc = 0;
        m_id = 0;
      end
    end
    m_pend = newp;
    m_srcq = s;
    m_irq = (m_id == 0) && ((m_pend & m_en) != 0);
  endtask

  // One clock cycle with the given register access; model tracks the edge.
  task automatic cyc(input logic rq, input logic w, input logic [3:0] a, input logic [31:0] wd);
    src_i = cur_src; req_i = rq; we_i = w; addr_i = a; wdata_i = wd;
    @(posedge clk_i);
    model_edge(cur_src, rq, w, a, wd);
    #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic idle(); cyc(1'b0, 1'b0, 4'h0, 32'd0); endtask
  task automatic rd(input logic [3:0] a); cyc(1'b1, 1'b0, a, 32'd0); endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d); cyc(1'b1, 1'b1, a, d); endtask

  task automatic test_reset();
    // Get irq_o and rvalid_o high, then drop reset mid-cycle.
    rst_ni = 1'b1; model_reset(); cur_src = 0;
    wr(4'h4, 32'h1);
    cur_src = 8'h01;
    idle();
    rd(4'h0);
    #2 rst_ni = 1'b0; model_reset(); cur_src = 0; src_i = 0;
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
    #3 rst_ni = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rd(4'(r * 4));
      checks++;
      if (rvalid_o !== 1'b1 || rdata_o !== 32'd0) begin
        errors++; $display("FAIL reset_read%0d got=%h/%b exp=0/1", r, rdata_o, rvalid_o);
      end
    end
  endtask

  task automatic test_edge();
    wr(4'h8, 32'h08); wr(4'h4, 32'h08);
    cur_src = 8'h08; idle(); cur_src = 0; idle();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL edge_irq got=%b exp=1", irq_o); end
    rd(4'h0);
    checks++; if (rdata_o !== 32'h08) begin errors++; $display("FAIL edge_pending got=%h exp=08", rdata_o); end
    rd(4'hC);
    checks++; if (rdata_o !== 32'd4) begin errors++; $display("FAIL edge_claim got=%0d exp=4", rdata_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_irq_drop got=%b exp=0", irq_o); end
    wr(4'hC, 32'd4); idle();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_complete_irq got=%b exp=0", irq_o); end
  endtask

  task automatic test_priority();
    wr(4'h8, 32'h22); wr(4'h4, 32'h22);
    cur_src = 8'h22; idle(); cur_src = 0; idle();
    rd(4'hC);
    checks++; if (rdata_o !== 32'd2) begin errors++; $display("FAIL prio_first got=%0d exp=2", rdata_o); end
    wr(4'hC, 32'd2);
    rd(4'hC);
    checks++; if (rdata_o !== 32'd6) begin errors++; $display("FAIL prio_second got=%0d exp=6", rdata_o); end
    wr(4'hC, 32'd6);
  endtask

  task automatic test_level();
    wr(4'h8, 32'h0); wr(4'h4, 32'h1);
    cur_src = 8'h01; idle();
    rd(4'hC);
    checks++; if (rdata_o !== 32'd1) begin errors++; $display("FAIL level_claim got=%0d exp=1", rdata_o); end
    rd(4'h0);
    checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL level_pend_claimed got=%h exp=0", rdata_o); end
    wr(4'hC, 32'd1); idle();
    rd(4'h0);
    checks++; if (rdata_o !== 32'h01) begin errors++; $display("FAIL level_repend got=%h exp=01", rdata_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL level_irq got=%b exp=1", irq_o); end
    cur_src = 0;
    rd(4'hC); wr(4'hC, 32'd1);
  endtask

  task automatic test_mask_and_bad_complete();
    wr(4'h4, 32'h0);
    cur_src = 8'h04; idle(); cur_src = 0; idle();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_irq got=%b exp=0", irq_o); end
    rd(4'hC);
    checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL mask_claim got=%0d exp=0", rdata_o); end
    wr(4'h4, 32'h04);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL unmask_irq got=%b exp=1", irq_o); end
    rd(4'hC);
    checks++; if (rdata_o !== 32'd3) begin errors++; $display("FAIL bad_claim got=%0d exp=3", rdata_o); end
    wr(4'hC, 32'd5);
    rd(4'hC);
    checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL bad_complete_claim got=%0d exp=0", rdata_o); end
    #2 rst_ni = 1'b0; model_reset(); #3 rst_ni = 1'b1;
    // After reset the old claim is gone: a fresh source 2 pend is claimable.
    wr(4'h4, 32'h04);
    cur_src = 8'h04; idle(); cur_src = 0;
    rd(4'hC);
    checks++; if (rdata_o !== 32'd3) begin errors++; $display("FAIL reset_abandon got=%0d exp=3", rdata_o); end
    wr(4'hC, 32'd3);
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [31:0] d;
    logic        rq, w;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) cur_src = 8'($urandom);
      rq = ($urandom_range(0, 2) != 0);
      w  = ($urandom_range(0, 2) == 0);
      a  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) a = 4'hC;
      d  = $urandom;
      if (a[3:2] == 2'd3 && $urandom_range(0, 1) == 1) d = 32'(m_id);
      cyc(rq, w, a, d);
      checks++;
      if (rvalid_o !== m_rvalid || rdata_o !== m_rdata || irq_o !== m_irq) begin
        errors++;
        $display("FAIL random[%0d] got rv=%b rd=%h irq=%b exp rv=%b rd=%h irq=%b",
                 n, rvalid_o, rdata_o, irq_o, m_rvalid, m_rdata, m_irq);
      end
    end
  endtask

  initial begin
    model_reset(); cur_src = 0;
    #12;
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_mask_and_bad_complete();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
